mdu: RTL and testbench
======================

// Module: mdu
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers; companion to the
//  single-cycle ALU in the EX stage of the pipelined MIPS CPU. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO,
//  models fixed multi-cycle latency and raises busy so hazard control stalls mfhi/mflo/MDU ops.
// PARAMETERS
//  WIDTH       32  operand and HI/LO width in bits (>=2)
//  MUL_CYCLES  5   cycles from accepted mult start to HI/LO commit (>=1)
//  DIV_CYCLES  10  cycles from accepted div start to HI/LO commit (>=1)
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      asynchronous reset, active low
//  start   in   1      op request, sampled on rising clk
//  MDUOp   in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 see CONFIGURATION
//  A       in   WIDTH  rs operand (dividend / multiplicand / MTHI,MTLO data)
//  B       in   WIDTH  rt operand (divisor / multiplier)
//  busy    out  1      registered; high while an op is in flight
//  HI      out  WIDTH  architectural HI register
//  LO      out  WIDTH  architectural LO register
// BEHAVIOUR
//  - One clock (clk); reset asynchronous, active-low (rst_n). Reset: busy=0, HI=0, LO=0, FSM=IDLE,
//    counter=0; reset mid-operation aborts it, no commit ever occurs for the aborted op.
//  - FSM IDLE/BUSY. IDLE & start & MDUOp in {MULT,MULTU}: capture A,B,op at edge T, load counter with
//    MUL_CYCLES, go BUSY (busy=1 after edge T). DIV/DIVU same with DIV_CYCLES.
//  - BUSY: counter decrements every edge; at edge T+N (N = latency) HI/LO take the result, busy=0,
//    FSM=IDLE. HI/LO hold their old values for the whole BUSY interval.
//  - MTHI/MTLO in IDLE: HI (resp. LO) <= A at edge T; busy stays 0; other register unchanged.
//  - start while BUSY (any op): ignored, no effect on result or timing; control is required to stall.
//    start on the commit edge itself is also ignored (FSM still BUSY when sampled).
//  - Undefined MDUOp values: ignored, FSM stays IDLE.
//  - MULT: {HI,LO} = signed A * signed B (2*WIDTH product). MULTU: unsigned product.
//  - DIV: LO = signed quotient truncated toward zero, HI = remainder with sign of A.
//    DIVU: unsigned quotient/remainder.
//  - Divide by zero (both): LO = all ones, HI = A, full DIV_CYCLES latency, no exception.
//  - DIV overflow (A = most-negative, B = -1): LO = A, HI = 0.
//  - Result computed from captured operands only; A/B changes during BUSY have no effect.
// CONFIGURATION
//  MDU_MADD_EN defined: 110 MADD, 111 MADDU accepted; {HI,LO} <= {HI,LO} + product (signed/unsigned
//  as MULT/MULTU, modulo 2^(2*WIDTH)), MUL_CYCLES latency; accumulator base = HI/LO value at commit.
//  Not defined: 110/111 treated as undefined opcodes (ignored, busy stays 0).
// TESTING
//  1 rst_n=0 mid-DIV (cycle 4 of 10) -> busy=0, HI=LO=0 immediately; no later commit.
//  2 MULT A=0xFFFFFFFE(-2) B=3 -> busy 1 for 5 cycles; then HI=0xFFFFFFFF LO=0xFFFFFFFA.
//    MULTU same -> HI=0x00000002 LO=0xFFFFFFFA.
//  3 DIV A=-7 B=2 -> after 10 cycles LO=0xFFFFFFFD(-3) HI=0xFFFFFFFF(-1); DIVU 7/2 -> LO=3 HI=1.
//  4 DIV A=5 B=0 -> LO=0xFFFFFFFF HI=5; DIV A=0x80000000 B=-1 -> LO=0x80000000 HI=0.
//  5 MTHI A=0x1234 then start MULT during BUSY of a prior DIV -> second start ignored, DIV result only.
//  6 MDU_MADD_EN: HI:LO=0:0xFFFFFFFF, MADDU A=1 B=1 -> HI=1 LO=0; without macro op 111 -> no change.

Source files
------------

// File: rtl/mdu.sv
// mdu -- multi-cycle multiply/divide unit with architectural HI/LO registers.
//
// Works alongside the single-cycle ALU in the EX stage. An accepted MULT/MULTU
// or DIV/DIVU captures its operands and raises busy for a fixed latency. When
// that latency expires, the result is committed to HI/LO. MTHI/MTLO write HI or
// LO from A in one cycle and never raise busy.
//
// Parameters:
//   WIDTH       operand and HI/LO width (>=2)
//   MUL_CYCLES  edges from an accepted multiply to its HI/LO commit (>=1)
//   DIV_CYCLES  edges from an accepted divide to its HI/LO commit (>=1)
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous reset, active low
//   start  in   operation request, sampled on the rising edge
//   MDUOp  in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   A      in   rs operand (dividend / multiplicand / MTHI,MTLO data)
//   B      in   rt operand (divisor / multiplier)
//   busy   out  high while an operation is in flight (decoded from state flop)
//   HI     out  architectural HI register
//   LO     out  architectural LO register
//
// Optional feature: define MDU_MADD_EN to accept 110 MADD / 111 MADDU, which add
// the product into {HI,LO}. Without it, 110/111 are ignored like any undefined op.

module mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       MDUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MADDU = 3'b111;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_nx;
  logic [CNT_W-1:0]       cnt;
  logic                   acc_mul, acc_div, wr_hi, wr_lo, commit;
  logic [2:0]             op_p0;
  logic [WIDTH-1:0]       a_p0, b_p0;
  logic [2*WIDTH-1:0]     res;

  // Full 2*WIDTH product; operands are sign- or zero-extended first, so the
  // low 2*WIDTH bits of the signed multiply are correct for both flavours.
  function automatic logic [2*WIDTH-1:0] mul_fn(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic             sgn);
    logic signed [2*WIDTH-1:0] sa, sb;
    sa = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    sb = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    return sa * sb;
  endfunction

  // Returns {remainder, quotient}. Divide-by-zero and the signed overflow case
  // are pinned to fixed results instead of relying on operator behaviour.
  function automatic logic [2*WIDTH-1:0] div_fn(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic             sgn);
    logic signed [WIDTH-1:0] sa, sb, sq, sr;
    if (b == '0)
      return {a, {WIDTH{1'b1}}};
    if (sgn) begin
      if (a == {1'b1, {(WIDTH-1){1'b0}}} && b == {WIDTH{1'b1}})
        return {{WIDTH{1'b0}}, a};
      sa = a;
      sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {sr, sq};
    end
    return {a % b, a / b};
  endfunction

  // Request decode: only honoured in IDLE; undefined ops fall through.
  always_comb begin
    acc_mul = 1'b0;
    acc_div = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    if (state == IDLE && start) begin
      case (MDUOp)
        OP_MULT, OP_MULTU: acc_mul = 1'b1;
`ifdef MDU_MADD_EN
        OP_MADD, OP_MADDU: acc_mul = 1'b1;
`endif
        OP_DIV, OP_DIVU:   acc_div = 1'b1;
        OP_MTHI:           wr_hi   = 1'b1;
        OP_MTLO:           wr_lo   = 1'b1;
        default: ;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (acc_mul || acc_div)  state_nx = BUSY;
      BUSY: if (cnt == CNT_W'(1))    state_nx = IDLE;
      default:                       state_nx = IDLE;
    endcase
  end

  // Outputs: commit happens on the edge where the counter leaves 1.
  always_comb begin
    busy   = (state == BUSY);
    commit = (state == BUSY) && (cnt == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (acc_mul)       cnt <= CNT_W'(MUL_CYCLES);
    else if (acc_div)       cnt <= CNT_W'(DIV_CYCLES);
    else if (state == BUSY) cnt <= cnt - CNT_W'(1);
  end

  // Stage p0: operand capture at acceptance
  always_ff @(posedge clk) begin
    if (acc_mul || acc_div) begin
      op_p0 <= MDUOp;
      a_p0  <= A;
      b_p0  <= B;
    end
  end

  always_comb begin
    res = {HI, LO};
    case (op_p0)
      OP_MULT:  res = mul_fn(a_p0, b_p0, 1'b1);
      OP_MULTU: res = mul_fn(a_p0, b_p0, 1'b0);
      OP_DIV:   res = div_fn(a_p0, b_p0, 1'b1);
      OP_DIVU:  res = div_fn(a_p0, b_p0, 1'b0);
`ifdef MDU_MADD_EN
      OP_MADD:  res = {HI, LO} + mul_fn(a_p0, b_p0, 1'b1);
      OP_MADDU: res = {HI, LO} + mul_fn(a_p0, b_p0, 1'b0);
`endif
      default: ;
    endcase
  end

  // Stage p1: architectural HI/LO commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HI <= '0;
      LO <= '0;
    end else if (commit) begin
      {HI, LO} <= res;
    end else begin
      if (wr_hi) HI <= A;
      if (wr_lo) LO <= A;
    end
  end

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  MDUOp = 3'b000;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .MDUOp(MDUOp),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  // One-cycle request; operands are scrambled right after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; MDUOp = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = ~a; B = b + 32'd1;
  endtask

  // Issues an op and counts sampled busy cycles; reports whether HI/LO held.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int ncyc, output bit held);
    logic [31:0] h0, l0;
    h0 = HI; l0 = LO;
    issue(op, a, b);
    ncyc = 0; held = 1'b1;
    while (busy === 1'b1 && ncyc < 40) begin
      ncyc++;
      if (HI !== h0 || LO !== l0) held = 1'b0;
      @(negedge clk);
    end
    if (ncyc >= 40) begin
      checks++; errors++;
      $display("FAIL do_op_timeout op=%0d busy still high after %0d cycles", op, ncyc);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (HI !== 32'h0)    begin errors++; $display("FAIL rst_hi got %h want 0", HI); end
    checks++; if (LO !== 32'h0)    begin errors++; $display("FAIL rst_lo got %h want 0", LO); end
    rst_n = 1'b1;
  endtask

  task automatic test_mthi_mtlo;
    int n; bit h;
    do_op(OP_MTHI, 32'h0000_1234, 32'h0, n, h);
    checks++; if (n !== 0)              begin errors++; $display("FAIL mthi_busy got %0d want 0", n); end
    checks++; if (HI !== 32'h0000_1234) begin errors++; $display("FAIL mthi_hi got %h want 00001234", HI); end
    checks++; if (LO !== 32'h0)         begin errors++; $display("FAIL mthi_lo got %h want 0", LO); end
    do_op(OP_MTLO, 32'h0000_0055, 32'h0, n, h);
    checks++; if (LO !== 32'h0000_0055) begin errors++; $display("FAIL mtlo_lo got %h want 00000055", LO); end
    checks++; if (HI !== 32'h0000_1234) begin errors++; $display("FAIL mtlo_hi got %h want 00001234", HI); end
  endtask

  task automatic test_reset_mid_div;
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (HI !== 32'h0)  begin errors++; $display("FAIL abort_hi got %h want 0", HI); end
    checks++; if (LO !== 32'h0)  begin errors++; $display("FAIL abort_lo got %h want 0", LO); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_late_busy got %b want 0", busy); end
    checks++; if (HI !== 32'h0)  begin errors++; $display("FAIL abort_late_hi got %h want 0", HI); end
    checks++; if (LO !== 32'h0)  begin errors++; $display("FAIL abort_late_lo got %h want 0", LO); end
  endtask

  task automatic test_mult;
    int n; bit h;
    do_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, n, h);
    checks++; if (n !== 5)              begin errors++; $display("FAIL mult_lat got %0d want 5", n); end
    checks++; if (h !== 1'b1)           begin errors++; $display("FAIL mult_hold got %b want 1", h); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", HI); end
    checks++; if (LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", LO); end
    do_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, n, h);
    checks++; if (n !== 5)              begin errors++; $display("FAIL multu_lat got %0d want 5", n); end
    checks++; if (h !== 1'b1)           begin errors++; $display("FAIL multu_hold got %b want 1", h); end
    checks++; if (HI !== 32'h0000_0002) begin errors++; $display("FAIL multu_hi got %h want 00000002", HI); end
    checks++; if (LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_lo got %h want fffffffa", LO); end
  endtask

  task automatic test_div;
    int n; bit h;
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, n, h);
    checks++; if (n !== 10)             begin errors++; $display("FAIL div_lat got %0d want 10", n); end
    checks++; if (h !== 1'b1)           begin errors++; $display("FAIL div_hold got %b want 1", h); end
    checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", LO); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", HI); end
    do_op(OP_DIVU, 32'd7, 32'd2, n, h);
    checks++; if (n !== 10)             begin errors++; $display("FAIL divu_lat got %0d want 10", n); end
    checks++; if (LO !== 32'd3)         begin errors++; $display("FAIL divu_lo got %h want 00000003", LO); end
    checks++; if (HI !== 32'd1)         begin errors++; $display("FAIL divu_hi got %h want 00000001", HI); end
  endtask

  task automatic test_div_corner;
    int n; bit h;
    do_op(OP_DIV, 32'd5, 32'd0, n, h);
    checks++; if (n !== 10)             begin errors++; $display("FAIL div0_lat got %0d want 10", n); end
    checks++; if (LO !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo got %h want ffffffff", LO); end
    checks++; if (HI !== 32'd5)         begin errors++; $display("FAIL div0_hi got %h want 00000005", HI); end
    do_op(OP_DIVU, 32'd9, 32'd0, n, h);
    checks++; if (LO !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo got %h want ffffffff", LO); end
    checks++; if (HI !== 32'd9)         begin errors++; $display("FAIL divu0_hi got %h want 00000009", HI); end
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n, h);
    checks++; if (LO !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo got %h want 80000000", LO); end
    checks++; if (HI !== 32'h0)         begin errors++; $display("FAIL divovf_hi got %h want 0", HI); end
  endtask

  task automatic test_back_to_back;
    int n; bit h;
    do_op(OP_MTHI, 32'h0000_1234, 32'h0, n, h);
    checks++; if (HI !== 32'h0000_1234) begin errors++; $display("FAIL b2b_mthi got %h want 00001234", HI); end
    issue(OP_DIV, 32'd20, 32'd6);
    repeat (2) @(negedge clk);
    start = 1'b1; MDUOp = OP_MULT; A = 32'h100; B = 32'h100;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; @(negedge clk); end
    checks++; if (n !== 7)      begin errors++; $display("FAIL b2b_remain got %0d want 7", n); end
    checks++; if (HI !== 32'd2) begin errors++; $display("FAIL b2b_hi got %h want 00000002", HI); end
    checks++; if (LO !== 32'd3) begin errors++; $display("FAIL b2b_lo got %h want 00000003", LO); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", busy); end
  endtask

  task automatic test_commit_edge;
    issue(OP_DIVU, 32'd23, 32'd5);
    repeat (9) @(negedge clk);
    start = 1'b1; MDUOp = OP_MULT; A = 32'd5; B = 32'd5;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cedge_busy got %b want 0", busy); end
    checks++; if (LO !== 32'd4)  begin errors++; $display("FAIL cedge_lo got %h want 00000004", LO); end
    checks++; if (HI !== 32'd3)  begin errors++; $display("FAIL cedge_hi got %h want 00000003", HI); end
    repeat (7) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cedge_late_busy got %b want 0", busy); end
    checks++; if (LO !== 32'd4)  begin errors++; $display("FAIL cedge_late_lo got %h want 00000004", LO); end
    checks++; if (HI !== 32'd3)  begin errors++; $display("FAIL cedge_late_hi got %h want 00000003", HI); end
  endtask

  task automatic test_madd;
    int n; bit h;
    do_op(OP_MTHI, 32'h0, 32'h0, n, h);
    do_op(OP_MTLO, 32'hFFFF_FFFF, 32'h0, n, h);
`ifdef MDU_MADD_EN
    do_op(3'b111, 32'd1, 32'd1, n, h);
    checks++; if (n !== 5)      begin errors++; $display("FAIL maddu_lat got %0d want 5", n); end
    checks++; if (HI !== 32'd1) begin errors++; $display("FAIL maddu_hi got %h want 00000001", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL maddu_lo got %h want 0", LO); end
    do_op(OP_MTHI, 32'h0, 32'h0, n, h);
    do_op(OP_MTLO, 32'd5, 32'h0, n, h);
    do_op(3'b110, 32'hFFFF_FFFE, 32'd3, n, h);
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL madd_hi got %h want ffffffff", HI); end
    checks++; if (LO !== 32'hFFFF_FFFF) begin errors++; $display("FAIL madd_lo got %h want ffffffff", LO); end
`else
    do_op(3'b111, 32'd1, 32'd1, n, h);
    checks++; if (n !== 0)              begin errors++; $display("FAIL op111_busy got %0d want 0", n); end
    checks++; if (HI !== 32'h0)         begin errors++; $display("FAIL op111_hi got %h want 0", HI); end
    checks++; if (LO !== 32'hFFFF_FFFF) begin errors++; $display("FAIL op111_lo got %h want ffffffff", LO); end
    do_op(3'b110, 32'd2, 32'd3, n, h);
    checks++; if (n !== 0)              begin errors++; $display("FAIL op110_busy got %0d want 0", n); end
    checks++; if (LO !== 32'hFFFF_FFFF) begin errors++; $display("FAIL op110_lo got %h want ffffffff", LO); end
`endif
  endtask

  initial begin
    test_reset;
    test_mthi_mtlo;
    test_reset_mid_div;
    test_mult;
    test_div;
    test_div_corner;
    test_back_to_back;
    test_commit_edge;
    test_madd;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
